vga_timing_driver: RTL and testbench

Generates 640x480@60 VGA raster timing and drives the VGA connector. Supplies `x_pos`/`y_pos` to the pixel renderer. Takes back the renderer's registered 12-bit colour and delays sync and blanking so they line up with it. Emits a once-per-frame tick that game logic uses to update.

---
 rtl/vga_timing_driver.sv | 183 ++++++++++++++++++
 tb/tb_vga_timing_driver.sv | 458 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_driver.sv
// -----------------------------------------------------------------------------
// vga_timing_driver
//
// Generates 640x480@60 VGA raster timing (geometry set by parameters), hands the
// raster position to a pixel renderer and drives the VGA connector with the
// renderer's colour. Sync and blanking are delayed so that they line up with
// the renderer's registered colour, and a one-clk tick marks the start of
// vertical blanking for game logic.
//
// Optional feature macro: VGA_CLK_DIV_EN
//   defined   : pixel step on every second clk (50 MHz clk -> 25 MHz pixels)
//   undefined : pixel step on every clk (clk expected at 25 MHz)
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   pixel_in   [11:0] renderer colour {R,G,B}, PIX_LATENCY steps behind x/y_pos
//   x_pos, y_pos [9:0] raster counters, counting through blanking
//   vga_r/g/b   [3:0] colour to the DAC, forced to 0 outside the visible area
//   hsync, vsync      active-low syncs, aligned with vga_*
//   active            visible-pixel flag, aligned with vga_*
//   frame_tick        one-clk pulse when the raster enters vertical blanking
// -----------------------------------------------------------------------------
module vga_timing_driver #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int PIX_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] pixel_in,
    output logic [9:0]  x_pos,
    output logic [9:0]  y_pos,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        hsync,
    output logic        vsync,
    output logic        active,
    output logic        frame_tick
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT     = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT     = 10'(V_ACTIVE);
    localparam logic [9:0] V_ACT_M1  = 10'(V_ACTIVE - 1);
    localparam logic [9:0] HS_START  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END    = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END    = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam int         DLY_LAST  = PIX_LATENCY - 1;

    // ------------------------------------------------------------------
    // Pixel step enable
    // ------------------------------------------------------------------
    logic w_step;

`ifdef VGA_CLK_DIV_EN
    // Toggle starts at 0, so the first pixel step is the second clk after reset.
    logic r_div;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= 1'b0;
        end else begin
            r_div <= ~r_div;
        end
    end

    assign w_step = r_div;
`else
    assign w_step = 1'b1;
`endif

    // ------------------------------------------------------------------
    // Raster counters
    // ------------------------------------------------------------------
    logic [9:0] r_h;
    logic [9:0] r_v;

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h <= '0;
            r_v <= '0;
        end else if (w_step) begin
            if (r_h == H_LAST) begin
                r_h <= '0;
                r_v <= (r_v == V_LAST) ? '0 : r_v + 10'd1;
            end else begin
                r_h <= r_h + 10'd1;
            end
        end
    end

    assign x_pos = r_h;
    assign y_pos = r_v;

    // ------------------------------------------------------------------
    // Raw timing at the current counter position
    // ------------------------------------------------------------------
    logic w_hs_raw;
    logic w_vs_raw;
    logic w_de_raw;

    assign w_hs_raw = !((r_h >= HS_START) && (r_h < HS_END));
    assign w_vs_raw = !((r_v >= VS_START) && (r_v < VS_END));
    assign w_de_raw = (r_h < H_ACT) && (r_v < V_ACT);

    // ------------------------------------------------------------------
    // Delay line matching the renderer latency
    // ------------------------------------------------------------------
    logic [PIX_LATENCY-1:0] r_hs_dly;
    logic [PIX_LATENCY-1:0] r_vs_dly;
    logic [PIX_LATENCY-1:0] r_de_dly;

    // NOTE: the delay stages are individual reset flops rather than an
    // unreset memory, so a reset mid-frame cannot leak a stale sync pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hs_dly <= '1;
            r_vs_dly <= '1;
            r_de_dly <= '0;
        end else if (w_step) begin
            r_hs_dly[0] <= w_hs_raw;
            r_vs_dly[0] <= w_vs_raw;
            r_de_dly[0] <= w_de_raw;
            for (int i = 1; i < PIX_LATENCY; i++) begin
                r_hs_dly[i] <= r_hs_dly[i-1];
                r_vs_dly[i] <= r_vs_dly[i-1];
                r_de_dly[i] <= r_de_dly[i-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    logic [11:0] r_rgb;
    logic        r_hsync;
    logic        r_vsync;
    logic        r_active;
    logic        r_frame_tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rgb        <= '0;
            r_hsync      <= 1'b1;
            r_vsync      <= 1'b1;
            r_active     <= 1'b0;
            r_frame_tick <= 1'b0;
        end else begin
            if (w_step) begin
                r_rgb    <= r_de_dly[DLY_LAST] ? pixel_in : 12'h000;
                r_hsync  <= r_hs_dly[DLY_LAST];
                r_vsync  <= r_vs_dly[DLY_LAST];
                r_active <= r_de_dly[DLY_LAST];
            end
            // Updated every clk so the pulse is one clk wide even when the
            // pixel step is divided down.
            r_frame_tick <= w_step && (r_h == H_LAST) && (r_v == V_ACT_M1);
        end
    end

    assign vga_r      = r_rgb[11:8];
    assign vga_g      = r_rgb[7:4];
    assign vga_b      = r_rgb[3:0];
    assign hsync      = r_hsync;
    assign vsync      = r_vsync;
    assign active     = r_active;
    assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_vga_timing_driver.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_driver
//
// Two instances share clock and reset: u_dut_a uses the full 640x480 geometry
// with PIX_LATENCY=1, u_dut_b a shrunken raster with PIX_LATENCY=3 so whole
// frames fit in a short run. A reference model derives every output from the
// number of pixel steps since reset release.
// -----------------------------------------------------------------------------
module tb_vga_timing_driver;

    localparam int HA_A = 640, HFP_A = 16, HS_A = 96, HBP_A = 48;
    localparam int VA_A = 480, VFP_A = 10, VS_A = 2,  VBP_A = 33;
    localparam int LAT_A = 1;
    localparam int HT_A = HA_A + HFP_A + HS_A + HBP_A;
    localparam int VT_A = VA_A + VFP_A + VS_A + VBP_A;
    localparam int FR_A = HT_A * VT_A;

    localparam int HA_B = 64, HFP_B = 4, HS_B = 8, HBP_B = 4;
    localparam int VA_B = 20, VFP_B = 2, VS_B = 2, VBP_B = 3;
    localparam int LAT_B = 3;
    localparam int HT_B = HA_B + HFP_B + HS_B + HBP_B;
    localparam int VT_B = VA_B + VFP_B + VS_B + VBP_B;
    localparam int FR_B = HT_B * VT_B;

    localparam int MAXN = 8192;

`ifdef VGA_CLK_DIV_EN
    localparam int CLK_PER_STEP = 2;
`else
    localparam int CLK_PER_STEP = 1;
`endif

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
        logic        de;
    } vis_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [11:0] pix_a = 12'h000;
    logic [11:0] pix_b = 12'h000;

    logic [9:0] a_x, a_y, b_x, b_y;
    logic [3:0] a_r, a_g, a_b, b_r, b_g, b_b;
    logic       a_hs, a_vs, a_de, a_tick, b_hs, b_vs, b_de, b_tick;

    always #5 clk = ~clk;

    vga_timing_driver #(
        .H_ACTIVE(HA_A), .H_FP(HFP_A), .H_SYNC(HS_A), .H_BP(HBP_A),
        .V_ACTIVE(VA_A), .V_FP(VFP_A), .V_SYNC(VS_A), .V_BP(VBP_A),
        .PIX_LATENCY(LAT_A)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n), .pixel_in(pix_a),
        .x_pos(a_x), .y_pos(a_y),
        .vga_r(a_r), .vga_g(a_g), .vga_b(a_b),
        .hsync(a_hs), .vsync(a_vs), .active(a_de), .frame_tick(a_tick)
    );

    vga_timing_driver #(
        .H_ACTIVE(HA_B), .H_FP(HFP_B), .H_SYNC(HS_B), .H_BP(HBP_B),
        .V_ACTIVE(VA_B), .V_FP(VFP_B), .V_SYNC(VS_B), .V_BP(VBP_B),
        .PIX_LATENCY(LAT_B)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .pixel_in(pix_b),
        .x_pos(b_x), .y_pos(b_y),
        .vga_r(b_r), .vga_g(b_g), .vga_b(b_b),
        .hsync(b_hs), .vsync(b_vs), .active(b_de), .frame_tick(b_tick)
    );

    int assert_cnt = 0;
    int fail_cnt   = 0;
    int n          = 0;   // pixel steps since reset release
    int cyc        = 0;   // clk edges since reset release
    int mode       = 2;   // 0 random, 1 echo renderer, 2 all-white
    logic [11:0] prev_a = 12'h000;
    logic [11:0] prev_b = 12'h000;

    logic [9:0]  obs_a_x   [MAXN];
    logic [9:0]  obs_a_y   [MAXN];
    logic [9:0]  obs_b_x   [MAXN];
    logic [9:0]  obs_b_y   [MAXN];
    logic [11:0] obs_a_rgb [MAXN];
    logic [11:0] obs_b_rgb [MAXN];
    logic        obs_a_hs  [MAXN];
    logic        obs_a_de  [MAXN];
    logic        obs_b_hs  [MAXN];
    logic        obs_b_vs  [MAXN];
    logic        obs_b_de  [MAXN];
    int          obs_cyc   [MAXN];
    int          tick_q[$];
    int          tick_clks = 0;

    // Expected visible outputs after k pixel steps: counters show step k, the
    // output stage shows the raster position PIX_LATENCY+1 steps earlier.
    function automatic vis_t model(int k, int ht, int vt, int ha, int hfp, int hsw,
                                   int va, int vfp, int vsw, int lat, logic [11:0] prev);
        vis_t e;
        int   m, h, v;
        e.x   = 10'(k % ht);
        e.y   = 10'((k / ht) % vt);
        e.hs  = 1'b1;
        e.vs  = 1'b1;
        e.de  = 1'b0;
        e.rgb = 12'h000;
        if (k >= lat + 1) begin
            m     = k - lat - 1;
            h     = m % ht;
            v     = (m / ht) % vt;
            e.hs  = !(h >= ha + hfp && h < ha + hfp + hsw);
            e.vs  = !(v >= va + vfp && v < va + vfp + vsw);
            e.de  = (h < ha) && (v < va);
            e.rgb = e.de ? prev : 12'h000;
        end
        return e;
    endfunction

    // A renderer that paints its column index, PIX_LATENCY steps late.
    function automatic logic [11:0] echo_pix(int k, int lat, int ht);
        if (k < lat) return 12'h000;
        return {2'b00, 10'((k - lat) % ht)};
    endfunction

    task automatic set_pixels();
        case (mode)
            0: begin
                pix_a = 12'($urandom);
                pix_b = 12'($urandom);
            end
            1: begin
                pix_a = echo_pix(n, LAT_A, HT_A);
                pix_b = echo_pix(n, LAT_B, HT_B);
            end
            default: begin
                pix_a = 12'hFFF;
                pix_b = 12'hFFF;
            end
        endcase
    endtask

    task automatic record_obs();
        if (n < MAXN) begin
            obs_a_x[n]   = a_x;   obs_a_y[n]   = a_y;
            obs_b_x[n]   = b_x;   obs_b_y[n]   = b_y;
            obs_a_rgb[n] = {a_r, a_g, a_b};
            obs_b_rgb[n] = {b_r, b_g, b_b};
            obs_a_hs[n]  = a_hs;  obs_a_de[n]  = a_de;
            obs_b_hs[n]  = b_hs;  obs_b_vs[n]  = b_vs;  obs_b_de[n] = b_de;
            obs_cyc[n]   = cyc;
        end
    endtask

    task automatic release_reset();
        rst_n  = 1'b1;
        n      = 0;
        cyc    = 0;
        prev_a = 12'h000;
        prev_b = 12'h000;
        tick_q.delete();
        tick_clks = 0;
        set_pixels();
        record_obs();
    endtask

    // Advance k pixel steps, scoring every clk against the model.
    task automatic run_steps(int k);
        int   done;
        logic step;
        logic ta, tb;
        vis_t ea, eb, oa, ob;
        done = 0;
        while (done < k) begin
            @(posedge clk);
            cyc++;
            step = ((cyc % CLK_PER_STEP) == 0);
            if (step) begin
                prev_a = pix_a;
                prev_b = pix_b;
                n++;
                done++;
            end
            @(negedge clk);
            ea = model(n, HT_A, VT_A, HA_A, HFP_A, HS_A, VA_A, VFP_A, VS_A, LAT_A, prev_a);
            eb = model(n, HT_B, VT_B, HA_B, HFP_B, HS_B, VA_B, VFP_B, VS_B, LAT_B, prev_b);
            oa = {a_x, a_y, a_r, a_g, a_b, a_hs, a_vs, a_de};
            ob = {b_x, b_y, b_r, b_g, b_b, b_hs, b_vs, b_de};
            assert_cnt++;
            if (oa !== ea) begin
                fail_cnt++;
                $display("FAIL model_a step=%0d got x=%0d y=%0d rgb=%h hs=%b vs=%b de=%b want x=%0d y=%0d rgb=%h hs=%b vs=%b de=%b",
                         n, oa.x, oa.y, oa.rgb, oa.hs, oa.vs, oa.de, ea.x, ea.y, ea.rgb, ea.hs, ea.vs, ea.de);
            end
            assert_cnt++;
            if (ob !== eb) begin
                fail_cnt++;
                $display("FAIL model_b step=%0d got x=%0d y=%0d rgb=%h hs=%b vs=%b de=%b want x=%0d y=%0d rgb=%h hs=%b vs=%b de=%b",
                         n, ob.x, ob.y, ob.rgb, ob.hs, ob.vs, ob.de, eb.x, eb.y, eb.rgb, eb.hs, eb.vs, eb.de);
            end
            ta = step && ((n % FR_A) == VA_A * HT_A);
            tb = step && ((n % FR_B) == VA_B * HT_B);
            assert_cnt++;
            if (a_tick !== ta) begin
                fail_cnt++;
                $display("FAIL tick_a step=%0d cyc=%0d got %b want %b", n, cyc, a_tick, ta);
            end
            assert_cnt++;
            if (b_tick !== tb) begin
                fail_cnt++;
                $display("FAIL tick_b step=%0d cyc=%0d got %b want %b", n, cyc, b_tick, tb);
            end
            if (b_tick === 1'b1) begin
                tick_clks++;
                if (step) tick_q.push_back(n);
            end
            if (step) begin
                record_obs();
                set_pixels();
            end
        end
    endtask

    task automatic test_reset();
        vis_t rv, oa, ob;
        rv    = {10'd0, 10'd0, 12'h000, 1'b1, 1'b1, 1'b0};
        mode  = 2;
        pix_a = 12'hFFF;
        pix_b = 12'hFFF;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        oa = {a_x, a_y, a_r, a_g, a_b, a_hs, a_vs, a_de};
        ob = {b_x, b_y, b_r, b_g, b_b, b_hs, b_vs, b_de};
        assert_cnt++;
        if (oa !== rv) begin
            fail_cnt++;
            $display("FAIL reset_a got %h want %h", oa, rv);
        end
        assert_cnt++;
        if (ob !== rv) begin
            fail_cnt++;
            $display("FAIL reset_b got %h want %h", ob, rv);
        end
        assert_cnt++;
        if ({a_tick, b_tick} !== 2'b00) begin
            fail_cnt++;
            $display("FAIL reset_tick got %b%b want 00", a_tick, b_tick);
        end
        release_reset();
        run_steps(3);
        for (int i = 0; i <= 3; i++) begin
            assert_cnt++;
            if (obs_a_x[i] !== 10'(i) || obs_b_x[i] !== 10'(i) || obs_a_y[i] !== 10'd0) begin
                fail_cnt++;
                $display("FAIL count_start step=%0d got xa=%0d xb=%0d ya=%0d want x=%0d y=0",
                         i, obs_a_x[i], obs_b_x[i], obs_a_y[i], i);
            end
        end
    endtask

    task automatic test_line_timing();
        int fall, low;
        mode = 0;
        set_pixels();
        run_steps(1700);
        assert_cnt++;
        if (obs_a_x[HT_A-1] !== 10'(HT_A - 1) || obs_a_y[HT_A-1] !== 10'd0) begin
            fail_cnt++;
            $display("FAIL line_end got x=%0d y=%0d want x=%0d y=0", obs_a_x[HT_A-1], obs_a_y[HT_A-1], HT_A - 1);
        end
        assert_cnt++;
        if (obs_a_x[HT_A] !== 10'd0 || obs_a_y[HT_A] !== 10'd1) begin
            fail_cnt++;
            $display("FAIL line_wrap got x=%0d y=%0d want x=0 y=1", obs_a_x[HT_A], obs_a_y[HT_A]);
        end
        assert_cnt++;
        if (obs_cyc[HT_A] - obs_cyc[0] !== HT_A * CLK_PER_STEP) begin
            fail_cnt++;
            $display("FAIL line_clks got %0d want %0d", obs_cyc[HT_A] - obs_cyc[0], HT_A * CLK_PER_STEP);
        end
        fall = -1;
        for (int k = 1; k < HT_A; k++) begin
            if (fall < 0 && obs_a_hs[k-1] === 1'b1 && obs_a_hs[k] === 1'b0) fall = k;
        end
        assert_cnt++;
        if (fall !== HA_A + HFP_A + LAT_A + 1) begin
            fail_cnt++;
            $display("FAIL hsync_start got step %0d want %0d", fall, HA_A + HFP_A + LAT_A + 1);
        end
        low = 0;
        if (fall >= 0) begin
            for (int k = fall; k < fall + HT_A; k++) if (obs_a_hs[k] === 1'b0) low++;
        end
        assert_cnt++;
        if (low !== HS_A) begin
            fail_cnt++;
            $display("FAIL hsync_width got %0d steps want %0d", low, HS_A);
        end
    endtask

    task automatic test_alignment();
        int ns, run_a, run_b, runs_b;
        logic seen0_a, seen0_b;
        mode = 1;
        set_pixels();
        ns = n;
        run_steps(2 * FR_B + 200);
        run_a = 0; run_b = 0; runs_b = 0;
        seen0_a = 1'b0; seen0_b = 1'b0;
        for (int k = ns + 1; k <= n; k++) begin
            if (obs_a_de[k] === 1'b1) begin
                assert_cnt++;
                if (obs_a_rgb[k] !== 12'((k - LAT_A - 1) % HT_A)) begin
                    fail_cnt++;
                    $display("FAIL echo_a step=%0d got %0d want %0d", k, obs_a_rgb[k], (k - LAT_A - 1) % HT_A);
                end
                if (seen0_a) run_a++;
            end else begin
                if (run_a > 0) begin
                    assert_cnt++;
                    if (run_a !== HA_A) begin
                        fail_cnt++;
                        $display("FAIL active_run_a ending step=%0d got %0d want %0d", k, run_a, HA_A);
                    end
                end
                run_a = 0;
                seen0_a = 1'b1;
            end
            if (obs_b_de[k] === 1'b1) begin
                assert_cnt++;
                if (obs_b_rgb[k] !== 12'((k - LAT_B - 1) % HT_B)) begin
                    fail_cnt++;
                    $display("FAIL echo_b step=%0d got %0d want %0d", k, obs_b_rgb[k], (k - LAT_B - 1) % HT_B);
                end
                if (seen0_b) run_b++;
            end else begin
                if (run_b > 0) begin
                    runs_b++;
                    assert_cnt++;
                    if (run_b !== HA_B) begin
                        fail_cnt++;
                        $display("FAIL active_run_b ending step=%0d got %0d want %0d", k, run_b, HA_B);
                    end
                end
                run_b = 0;
                seen0_b = 1'b1;
            end
        end
        assert_cnt++;
        if (runs_b < 2 * VA_B - 2) begin
            fail_cnt++;
            $display("FAIL active_lines_b got %0d complete lines want at least %0d", runs_b, 2 * VA_B - 2);
        end
    endtask

    task automatic test_frame();
        int lo, fall, cnt;
        mode = 0;
        set_pixels();
        run_steps(300);
        lo = 0;
        fall = -1;
        for (int k = LAT_B + 1; k < LAT_B + 1 + 2 * FR_B; k++) begin
            if (obs_b_vs[k] === 1'b0) lo++;
            if (fall < 0 && obs_b_vs[k-1] === 1'b1 && obs_b_vs[k] === 1'b0) fall = k;
        end
        assert_cnt++;
        if (lo !== 2 * VS_B * HT_B) begin
            fail_cnt++;
            $display("FAIL vsync_width got %0d steps over two frames want %0d", lo, 2 * VS_B * HT_B);
        end
        assert_cnt++;
        if (fall !== (VA_B + VFP_B) * HT_B + LAT_B + 1) begin
            fail_cnt++;
            $display("FAIL vsync_start got step %0d want %0d", fall, (VA_B + VFP_B) * HT_B + LAT_B + 1);
        end
        cnt = 0;
        for (int t = VA_B * HT_B; t <= n; t += FR_B) cnt++;
        assert_cnt++;
        if (tick_q.size() !== cnt) begin
            fail_cnt++;
            $display("FAIL tick_count got %0d want %0d", tick_q.size(), cnt);
        end
        assert_cnt++;
        if (tick_clks !== cnt) begin
            fail_cnt++;
            $display("FAIL tick_width got %0d high clks want %0d", tick_clks, cnt);
        end
        foreach (tick_q[i]) begin
            assert_cnt++;
            if (tick_q[i] !== VA_B * HT_B + i * FR_B || obs_b_y[tick_q[i]] !== 10'(VA_B) ||
                obs_b_x[tick_q[i]] !== 10'd0) begin
                fail_cnt++;
                $display("FAIL tick_pos idx=%0d got step %0d want %0d", i, tick_q[i], VA_B * HT_B + i * FR_B);
            end
        end
    endtask

    task automatic test_blanking_reset();
        int ns;
        vis_t rv, oa, ob;
        rv   = {10'd0, 10'd0, 12'h000, 1'b1, 1'b1, 1'b0};
        mode = 2;
        set_pixels();
        ns = n;
        run_steps(400);
        for (int k = ns + 1; k <= n; k++) begin
            assert_cnt++;
            if (obs_a_rgb[k] !== (obs_a_de[k] ? 12'hFFF : 12'h000) ||
                obs_b_rgb[k] !== (obs_b_de[k] ? 12'hFFF : 12'h000)) begin
                fail_cnt++;
                $display("FAIL blanking step=%0d got a=%h(de %b) b=%h(de %b)",
                         k, obs_a_rgb[k], obs_a_de[k], obs_b_rgb[k], obs_b_de[k]);
            end
        end
        run_steps($urandom_range(0, FR_B - 1));
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        oa = {a_x, a_y, a_r, a_g, a_b, a_hs, a_vs, a_de};
        ob = {b_x, b_y, b_r, b_g, b_b, b_hs, b_vs, b_de};
        assert_cnt++;
        if (oa !== rv || a_tick !== 1'b0) begin
            fail_cnt++;
            $display("FAIL midreset_a got %h tick %b want %h tick 0", oa, a_tick, rv);
        end
        assert_cnt++;
        if (ob !== rv || b_tick !== 1'b0) begin
            fail_cnt++;
            $display("FAIL midreset_b got %h tick %b want %h tick 0", ob, b_tick, rv);
        end
        repeat (2) @(negedge clk);
        release_reset();
        run_steps(4);
        for (int i = 0; i <= 4; i++) begin
            assert_cnt++;
            if (obs_a_x[i] !== 10'(i) || obs_b_x[i] !== 10'(i) || obs_b_y[i] !== 10'd0 ||
                obs_a_hs[i] !== 1'b1 || obs_b_hs[i] !== 1'b1 || obs_b_vs[i] !== 1'b1) begin
                fail_cnt++;
                $display("FAIL restart step=%0d got xa=%0d xb=%0d yb=%0d hs=%b%b vs=%b want x=%0d y=0 syncs high",
                         i, obs_a_x[i], obs_b_x[i], obs_b_y[i], obs_a_hs[i], obs_b_hs[i], obs_b_vs[i], i);
            end
        end
    endtask

    initial begin
        test_reset();
        test_line_timing();
        test_alignment();
        test_frame();
        test_blanking_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
